// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. It holds the program counter and the F/D
// pipeline latch, and runs a two-state RUN/REDIRECT control machine.
// Instruction memory is read combinationally: the PC goes out on imem_addr
// and the word at that address comes back on imem_data in the same cycle.
//
// An execute-stage redirect (branch_or_jump_taken) always wins over a decode
// stall. It loads the target into the PC and leaves a bubble in F/D.
//
// Optional feature, enabled by defining FETCH_PERF_CNT_EN:
//   perf_fetch_cnt / perf_flush_cnt performance counters.
//
// Ports
//   clock                 in   rising-edge clock
//   reset                 in   asynchronous, active-high reset
//   stall                 in   decode hazard: hold PC and F/D latch
//   branch_or_jump_taken  in   execute-stage redirect request
//   pc_next[31:0]         in   redirect target
//   imem_data[31:0]       in   instruction word at imem_addr (same cycle)
//   imem_addr[31:0]       out  current PC
//   pc_next_def[31:0]     out  PC + 1 (wraps modulo 2^32)
//   fd_pc_out[31:0]       out  PC + 1 of the instruction in F/D
//   fd_ir_out[31:0]       out  instruction in F/D (zero when a bubble)
//   fd_valid              out  F/D holds a real instruction
//   dx_flush              out  decode must insert a bubble into D/X
//   perf_fetch_cnt[31:0]  out  instructions accepted into F/D (FETCH_PERF_CNT_EN)
//   perf_flush_cnt[31:0]  out  redirect events (FETCH_PERF_CNT_EN)
// ---------------------------------------------------------------------------
module fetch_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_or_jump_taken,
  input  logic [31:0] pc_next,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_next_def,
  output logic [31:0] fd_pc_out,
  output logic [31:0] fd_ir_out,
  output logic        fd_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic        dx_flush
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } fetch_state_t;

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic [31:0]  fd_ir_r;
  logic [31:0]  fd_pc_r;
  logic         fd_valid_r;
  logic [31:0]  pc_inc_s;

  // The sequential successor wraps naturally through the 32-bit adder.
  assign pc_inc_s    = pc_r + 32'd1;
  assign imem_addr   = pc_r;
  assign pc_next_def = pc_inc_s;
  assign fd_pc_out   = fd_pc_r;
  assign fd_ir_out   = fd_ir_r;
  assign fd_valid    = fd_valid_r;
  assign dx_flush    = branch_or_jump_taken;

  // PC, F/D latch and RUN/REDIRECT state; a redirect takes priority over stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_RUN;
      pc_r       <= 32'd0;
      fd_ir_r    <= 32'd0;
      fd_pc_r    <= 32'd0;
      fd_valid_r <= 1'b0;
    end else if (branch_or_jump_taken) begin
      // fd_pc is left alone. It carries no meaning while fd_valid is low.
      state_r    <= ST_REDIRECT;
      pc_r       <= pc_next;
      fd_ir_r    <= 32'd0;
      fd_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (!stall) begin
            pc_r       <= pc_inc_s;
            fd_ir_r    <= imem_data;
            fd_pc_r    <= pc_inc_s;
            fd_valid_r <= 1'b1;
          end else begin
            pc_r       <= pc_r;
            fd_valid_r <= fd_valid_r;
          end
        end
        ST_REDIRECT: begin
          if (!stall) begin
            state_r    <= ST_RUN;
            pc_r       <= pc_inc_s;
            fd_ir_r    <= imem_data;
            fd_pc_r    <= pc_inc_s;
            fd_valid_r <= 1'b1;
          end else begin
            // Keep the redirect bubble in F/D until fetch can proceed.
            fd_ir_r    <= 32'd0;
            fd_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_RUN;
          fd_ir_r    <= 32'd0;
          fd_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_r;
  logic [31:0] perf_flush_cnt_r;

  assign perf_fetch_cnt = perf_fetch_cnt_r;
  assign perf_flush_cnt = perf_flush_cnt_r;

  // Event counters: real fetches into F/D, and cycles with a redirect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt_r <= 32'd0;
      perf_flush_cnt_r <= 32'd0;
    end else if (branch_or_jump_taken) begin
      perf_flush_cnt_r <= perf_flush_cnt_r + 32'd1;
    end else if (!stall) begin
      perf_fetch_cnt_r <= perf_fetch_cnt_r + 32'd1;
    end else begin
      perf_fetch_cnt_r <= perf_fetch_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed and randomized stimulus for fetch_stage. Expected values come
// from a transaction-level model of the fetch stage. The model tracks the
// architectural PC, the F/D contents and the counter totals. Instruction
// memory is a fixed function of the address, so the model knows which word
// each fetch must return.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        branch_or_jump_taken;
  logic [31:0] pc_next;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] pc_next_def;
  logic [31:0] fd_pc_out;
  logic [31:0] fd_ir_out;
  logic        fd_valid;
  logic        dx_flush;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int total;
  int bad;

  // Model state
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_fdpc;
  logic        m_valid;
  logic [31:0] m_fetch;
  logic [31:0] m_flush;

  fetch_stage dut (
    .clock                (clock),
    .reset                (reset),
    .stall                (stall),
    .branch_or_jump_taken (branch_or_jump_taken),
    .pc_next              (pc_next),
    .imem_data            (imem_data),
    .imem_addr            (imem_addr),
    .pc_next_def          (pc_next_def),
    .fd_pc_out            (fd_pc_out),
    .fd_ir_out            (fd_ir_out),
    .fd_valid             (fd_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt       (perf_fetch_cnt),
    .perf_flush_cnt       (perf_flush_cnt),
`endif
    .dx_flush             (dx_flush)
  );

  // Instruction memory contents: address 0,1,2 hold 32'hA, 32'hB, 32'hC.
  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    return a + 32'hA;
  endfunction

  assign imem_data = imem_fn(imem_addr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_ir = 32'd0; m_fdpc = 32'd0; m_valid = 1'b0;
    m_fetch = 32'd0; m_flush = 32'd0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_addr"}, imem_addr, m_pc);
    chk({tag, "_pcdef"}, pc_next_def, m_pc + 32'd1);
    chk({tag, "_valid"}, {31'd0, fd_valid}, {31'd0, m_valid});
    chk({tag, "_ir"}, fd_ir_out, m_ir);
    if (m_valid) chk({tag, "_fdpc"}, fd_pc_out, m_fdpc);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_pfetch"}, perf_fetch_cnt, m_fetch);
    chk({tag, "_pflush"}, perf_flush_cnt, m_flush);
`endif
  endtask

  // One clock edge. It starts and ends at a negedge. Inputs are driven here,
  // the combinational outputs are checked before the edge, and the state is
  // checked after it.
  task automatic step(input logic tk, input logic st, input logic [31:0] tgt, input string tag);
    branch_or_jump_taken = tk;
    stall = st;
    pc_next = tgt;
    #1;
    chk({tag, "_flush"}, {31'd0, dx_flush}, {31'd0, tk});
    chk({tag, "_preaddr"}, imem_addr, m_pc);
    @(posedge clock);
    if (tk) begin
      m_pc = tgt; m_ir = 32'd0; m_valid = 1'b0; m_flush = m_flush + 32'd1;
    end else if (!st) begin
      m_ir = imem_fn(m_pc); m_pc = m_pc + 32'd1; m_fdpc = m_pc;
      m_valid = 1'b1; m_fetch = m_fetch + 32'd1;
    end
    #1;
    check_state(tag);
    @(negedge clock);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    stall = 1'b0;
    branch_or_jump_taken = 1'b0;
    pc_next = 32'd0;
    model_reset();
    #1;
    check_state("rst");
    @(negedge clock);
    reset = 1'b0;

    // First fetches after reset: addresses 0, 1, 2
    step(1'b0, 1'b0, 32'd0, "f0");
    step(1'b0, 1'b0, 32'd0, "f1");
    step(1'b0, 1'b0, 32'd0, "f2");
    chk("r035_ir", fd_ir_out, 32'hC);
    chk("r035_fdpc", fd_pc_out, 32'd3);
    chk("r035_addr", imem_addr, 32'd3);

    // Stall at PC 5
    step(1'b0, 1'b0, 32'd0, "f3");
    step(1'b0, 1'b0, 32'd0, "f4");
    chk("r036_pc5", imem_addr, 32'd5);
    step(1'b0, 1'b1, 32'd0, "st0");
    step(1'b0, 1'b1, 32'd0, "st1");
    chk("r036_hold", imem_addr, 32'd5);
    step(1'b0, 1'b0, 32'd0, "resume");
    chk("r036_ir", fd_ir_out, imem_fn(32'd5));

    // Redirect at PC 8
    step(1'b0, 1'b0, 32'd0, "f6");
    step(1'b0, 1'b0, 32'd0, "f7");
    chk("r037_pc8", imem_addr, 32'd8);
    step(1'b1, 1'b0, 32'h40, "redir");
    chk("r037_addr", imem_addr, 32'h40);
    step(1'b0, 1'b0, 32'd0, "after");
    chk("r037_fdpc", fd_pc_out, 32'h41);

    // Redirect and stall together, then stalls while in REDIRECT
    step(1'b1, 1'b1, 32'h20, "tkst");
    chk("r038_pc", imem_addr, 32'h20);
    step(1'b0, 1'b1, 32'd0, "rdst0");
    step(1'b0, 1'b1, 32'd0, "rdst1");
    step(1'b1, 1'b0, 32'h30, "b2b0");
    step(1'b1, 1'b0, 32'h50, "b2b1");
    step(1'b0, 1'b0, 32'd0, "b2b2");

    // PC wrap
    step(1'b1, 1'b0, 32'hFFFFFFFF, "wrapr");
    chk("r039_pcdef", pc_next_def, 32'd0);
    step(1'b0, 1'b0, 32'd0, "wrap");
    chk("r039_addr", imem_addr, 32'd0);

    // Reset pulse between edges while in REDIRECT
    step(1'b1, 1'b0, 32'h77, "prerst");
    branch_or_jump_taken = 1'b0;
    stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_state("midrst");
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_state("postrst");
    stall = 1'b0;
    step(1'b0, 1'b0, 32'd0, "refetch");
    chk("r031_ir", fd_ir_out, 32'hA);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic tk;
      logic st;
      tk = ($urandom_range(7) == 0);
      st = ($urandom_range(3) == 0);
      step(tk, st, $urandom, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port: clock  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state.
REQ-003 SHALL have port: stall  input  1  decode hazard; hold PC and F/D latch.
REQ-004 SHALL have port: branch_or_jump_taken  input  1  execute-stage redirect request.
REQ-005 SHALL have port: pc_next  input  32  redirect target from execute stage.
REQ-006 SHALL have port: imem_data  input  32  instruction word at imem_addr, valid same cycle.
REQ-007 SHALL have port: imem_addr  output  32  current PC register value.
REQ-008 SHALL have port: pc_next_def  output  32  sequential successor, PC+1.
REQ-009 SHALL have port: fd_pc_out  output  32  PC+1 of the instruction held in the F/D latch.
REQ-010 SHALL have port: fd_ir_out  output  32  instruction held in the F/D latch.
REQ-011 SHALL have port: fd_valid  output  1  F/D latch holds a real instruction, not a bubble.
REQ-012 SHALL have port: dx_flush  output  1  decode must load a bubble into D/X this cycle.
REQ-013 SHALL have port, only with FETCH_PERF_CNT_EN: perf_fetch_cnt  output  32  instructions accepted into F/D.
REQ-014 SHALL have port, only with FETCH_PERF_CNT_EN: perf_flush_cnt  output  32  redirect events.

Function
REQ-015 SHALL use one clock and an asynchronous, active-high reset.
REQ-016 SHALL compute pc_next_def = PC + 1, modulo 2^32; 32'hFFFFFFFF wraps to 0.
REQ-017 SHALL drive imem_addr = PC combinationally, with no added latency.
REQ-018 SHALL hold a two-state FSM: RUN, REDIRECT.
REQ-019 In RUN, with taken=0 and stall=0, SHALL load PC <= pc_next_def, fd_ir <= imem_data, fd_pc <= pc_next_def, fd_valid <= 1.
REQ-020 In RUN, with taken=0 and stall=1, SHALL hold PC, fd_ir, fd_pc and fd_valid unchanged.
REQ-021 With taken=1, in any state, SHALL load PC <= pc_next, fd_ir <= 32'h0 (nop), fd_valid <= 0, and go to REDIRECT.
REQ-022 SHALL drive dx_flush = branch_or_jump_taken combinationally.
REQ-023 When taken and stall are high together, taken SHALL win and stall SHALL be ignored.
REQ-024 In REDIRECT, SHALL fetch normally per REQ-019/020 and return to RUN on the first non-stalled, non-taken edge.
REQ-025 While in REDIRECT under stall, SHALL keep fd_valid = 0 and remain in REDIRECT.
REQ-026 SHALL take a fresh taken in REDIRECT per REQ-021; back-to-back redirects are legal.
REQ-027 SHALL keep fd_ir_out = 0 whenever fd_valid = 0.

Reset
REQ-028 On reset assertion, SHALL immediately set PC = 0, fd_ir = 0, fd_pc = 0, fd_valid = 0 and FSM = RUN, independent of clock.
REQ-029 With reset held, SHALL drive pc_next_def = 1 and imem_addr = 0.
REQ-030 When reset asserts mid-stall or mid-redirect, SHALL drop the pending action with no residual effect.
REQ-031 SHALL perform the first fetch at address 0 on the first rising edge after reset deasserts.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN defined: SHALL add perf_fetch_cnt (+1 per REQ-019 load with fd_valid <= 1) and perf_flush_cnt (+1 per cycle with taken=1).
REQ-033 Both counters SHALL reset to 0 and wrap at 2^32.
REQ-034 Macro FETCH_PERF_CNT_EN undefined: SHALL omit both ports and all counter logic; remaining behaviour is unchanged.

Verification
REQ-035 Reset, then 3 edges, imem returns 32'hA, 32'hB, 32'hC -> imem_addr 0,1,2,3; fd_ir_out = 32'hC; fd_pc_out = 3; fd_valid = 1.
REQ-036 PC = 5, stall high for 2 edges -> imem_addr stays 5; fd_ir_out and fd_pc_out unchanged; resume fetches 5.
REQ-037 PC = 8, taken=1, pc_next = 32'h40 -> dx_flush = 1 that cycle; next edge: imem_addr = 32'h40, fd_valid = 0, fd_ir_out = 0; following edge: fd_valid = 1, fd_pc_out = 32'h41.
REQ-038 taken=1 and stall=1 together, pc_next = 32'h20 -> PC = 32'h20, bubble in F/D.
REQ-039 PC = 32'hFFFFFFFF, no stall -> pc_next_def = 0; next imem_addr = 0.
REQ-040 Reset pulsed between clock edges during REDIRECT -> all outputs 0 (pc_next_def = 1) before the next edge; with FETCH_PERF_CNT_EN, counters read 0.
